// File: rtl/demux_deser_if.sv
// Bus between the mux-driven serial link and the deserialiser.
// The master drives the serial side; the slave (the deserialiser) drives the
// recovered word, the lane index and the status pulses.
interface demux_deser_if #(
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    // Serial side
    logic             y_in;
    logic             in_valid;
    logic             sync;

    // Recovered side
    logic [N-1:0]     D_out;
    logic             out_valid;
    logic [SEL_W-1:0] sel_out;
    logic [N-1:0]     en;
    logic             frame_err;

    modport master (
        output y_in,
        output in_valid,
        output sync,
        input  D_out,
        input  out_valid,
        input  sel_out,
        input  en,
        input  frame_err
    );

    modport slave (
        input  y_in,
        input  in_valid,
        input  sync,
        output D_out,
        output out_valid,
        output sel_out,
        output en,
        output frame_err
    );
endinterface

// File: rtl/demux_deser.sv
// Serial-to-parallel recovery for a select-mux link.
// Each accepted bit lands in the lane given by the lane counter (or lane 0 when
// sync is asserted); after N accepted bits the complete word is published on
// D_out together with a one-cycle out_valid pulse. Partial frames live only in
// the shadow register, so D_out never shows a half-built word.
module demux_deser #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    demux_deser_if.slave    bus
);

    // Index of the last lane; reaching it closes a frame.
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N - 1);

    logic [N-1:0]     r_shd;
    logic [N-1:0]     r_dout;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_sel;
    logic             r_frame_err;

    logic [SEL_W-1:0] w_lane;
    logic             w_last;
    logic [N-1:0]     w_word;
    logic [N-1:0]     w_en;

    // Lane for the current bit: sync restarts the frame at lane 0.
    always_comb begin
        w_lane = bus.sync ? '0 : r_sel;
        w_last = (w_lane == LAST_LANE);
    end

    // The finished word is the shadow with its top lane taken straight from
    // y_in, so the frame can be published on the same edge the last bit arrives.
    assign w_word = {bus.y_in, r_shd[N-2:0]};

    // One-hot lane enable, decoded only from the registered lane counter so
    // there is no combinational path from the inputs to en.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_en
            assign w_en[gi] = (r_sel == SEL_W'(gi));
        end
    endgenerate

    // Lane counter, shadow capture, word publication and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shd       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_sel       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            // Both status outputs are single-cycle pulses by default.
            r_out_valid <= 1'b0;
            // A sync while mid-frame abandons the partial word and flags it.
            r_frame_err <= bus.sync && (r_sel != '0);

            if (bus.in_valid) begin
                r_shd[w_lane] <= bus.y_in;
                if (w_last) begin
                    r_sel       <= '0;
                    r_dout      <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_sel <= w_lane + SEL_W'(1);
                end
            end else if (bus.sync) begin
                // Sync without data only rewinds the lane counter; stale shadow
                // bits are overwritten before they can reach D_out.
                r_sel <= '0;
            end
        end
    end

    assign bus.D_out     = r_dout;
    assign bus.out_valid = r_out_valid;
    assign bus.sel_out   = r_sel;
    assign bus.en        = w_en;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_demux_deser.sv
// Self-checking bench for demux_deser: directed scenarios followed by random
// traffic, every cycle compared against a queue-based frame model.
module tb_demux_deser;

    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_deser_if #(.N(N), .SEL_W(SEL_W)) bus ();

    demux_deser #(.N(N), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks  = 0;
    int n_errors  = 0;
    int n_pulses  = 0;
    int n_ferr    = 0;
    int cycle     = 0;
    int last_pulse_cycle = 0;
    int prev_pulse_cycle = 0;

    // Model state: bits of the frame being collected, in arrival order.
    bit             fq[$];
    logic [N-1:0]   e_dout;
    logic           e_ov;
    logic           e_ferr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Frame-level model: a frame is the list of accepted bits since the last
    // frame boundary; sync restarts the list, N bits publish a word.
    task automatic model(input logic r, input logic v, input logic y, input logic s);
        if (r) begin
            fq.delete();
            e_dout = '0;
            e_ov   = 1'b0;
            e_ferr = 1'b0;
        end else begin
            e_ov   = 1'b0;
            e_ferr = s && (fq.size() != 0);
            if (s) fq.delete();
            if (v) begin
                fq.push_back(y);
                if (fq.size() == N) begin
                    e_dout = '0;
                    foreach (fq[i]) e_dout[i] = fq[i];
                    e_ov = 1'b1;
                    fq.delete();
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, update the model,
    // then compare every output half a cycle later.
    task automatic step(input logic r, input logic v, input logic y, input logic s);
        logic [N-1:0] exp_en;
        rst          = r;
        bus.in_valid = v;
        bus.y_in     = y;
        bus.sync     = s;
        @(posedge clk);
        cycle++;
        model(r, v, y, s);
        @(negedge clk);
        exp_en = N'(1) << fq.size();
        chk("D_out",     32'(bus.D_out),     32'(e_dout));
        chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
        chk("sel_out",   32'(bus.sel_out),   32'(fq.size()));
        chk("en",        32'(bus.en),        32'(exp_en));
        chk("frame_err", 32'(bus.frame_err), 32'(e_ferr));
        if (bus.out_valid === 1'b1) begin
            n_pulses++;
            prev_pulse_cycle = last_pulse_cycle;
            last_pulse_cycle = cycle;
            $display("cycle %0d: frame D_out=%b", cycle, bus.D_out);
        end
        if (bus.frame_err === 1'b1) begin
            n_ferr++;
            $display("cycle %0d: frame_err pulse", cycle);
        end
    endtask

    task automatic send(input logic y);
        step(1'b0, 1'b1, y, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int p0;
        int f0;
        logic r, v, y, s;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_D_out", 32'(bus.D_out), 32'h0);
        chk("rst_en",    32'(bus.en),    32'h1);

        // 1) 0,1,1,0 back to back
        p0 = n_pulses;
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        chk("t1_D_out",  32'(bus.D_out),     32'h6);
        chk("t1_ov",     32'(bus.out_valid), 32'h1);
        chk("t1_sel",    32'(bus.sel_out),   32'h0);
        idle(1);
        chk("t1_pulses", 32'(n_pulses - p0), 32'h1);

        // 2) same bits with 3 idle cycles between each
        p0 = n_pulses;
        send(1'b0); idle(3);
        send(1'b1); idle(3);
        chk("t2_gap_sel", 32'(bus.sel_out), 32'h2);
        chk("t2_gap_en",  32'(bus.en),      32'h4);
        send(1'b1); idle(3);
        send(1'b0);
        chk("t2_D_out",  32'(bus.D_out), 32'h6);
        idle(3);
        chk("t2_pulses", 32'(n_pulses - p0), 32'h1);

        // 3) 0110 then 1111 back to back
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        chk("t3_D_out_a", 32'(bus.D_out), 32'h6);
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        chk("t3_D_out_b", 32'(bus.D_out), 32'hF);
        chk("t3_spacing", 32'(last_pulse_cycle - prev_pulse_cycle), 32'h4);
        idle(1);

        // 4) 1,1 then sync+bit 1, then 0,0,1
        f0 = n_ferr;
        send(1'b1); send(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_ferr", 32'(bus.frame_err), 32'h1);
        chk("t4_sel",  32'(bus.sel_out),   32'h1);
        send(1'b0); send(1'b0); send(1'b1);
        chk("t4_D_out", 32'(bus.D_out), 32'h9);
        chk("t4_ferr_count", 32'(n_ferr - f0), 32'h1);
        idle(1);

        // 5) 3 bits, reset, then 1,0,1,0
        p0 = n_pulses;
        send(1'b1); send(1'b1); send(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_no_pulse", 32'(n_pulses - p0), 32'h0);
        chk("t5_rst_D_out", 32'(bus.D_out), 32'h0);
        chk("t5_rst_sel",   32'(bus.sel_out), 32'h0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("t5_D_out", 32'(bus.D_out), 32'h5);
        idle(1);

        // 6) sync alone at lane 0, then en sweep
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_no_ferr", 32'(bus.frame_err), 32'h0);
        chk("t6_en0", 32'(bus.en), 32'h1);
        send(1'b0); chk("t6_en1", 32'(bus.en), 32'h2);
        send(1'b0); chk("t6_en2", 32'(bus.en), 32'h4);
        send(1'b0); chk("t6_en3", 32'(bus.en), 32'h8);
        send(1'b0); chk("t6_en_wrap", 32'(bus.en), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 11) == 0);
            y = 1'($urandom);
            step(r, v, y, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
